// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU core (port 0) and the DMA/loader (port 1).
// Define MEM_ARB_LOCK_EN to let a requester keep ownership across transactions via lock0/lock1.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // state    | meaning
    // ST_IDLE  | sample requests, grant one
    // ST_ISSUE | mem_en strobe with captured request
    // ST_WAIT  | read latency countdown, capture mem_rdata on terminal count
    // ST_DONE  | ack pulse to the granted port
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);
    localparam logic [2:0]    LAT_LOAD  = 3'(RD_LAT);

    state_t        r_state;
    logic          r_gnt;
    logic          r_last_grant;
    logic [2:0]    r_wait_cnt;

    logic          w_grant_valid;
    logic          w_grant_port;
    logic          w_sel_rw;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_lock_active;
    logic          w_owner_port;
    logic          w_owner_req;

`ifdef MEM_ARB_LOCK_EN
    logic r_cap_lock;
    logic r_locked;
    logic r_owner;
    logic w_owner_lock;
    logic w_lock_release;

    assign w_owner_port   = r_owner;
    assign w_owner_req    = r_owner ? req1 : req0;
    assign w_owner_lock   = r_owner ? lock1 : lock0;
    assign w_lock_release = r_locked && !w_owner_req && !w_owner_lock;
    assign w_lock_active  = r_locked && !w_lock_release;

    // Lock is taken or dropped when a transaction completes, based on the lock captured at grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_lock <= 1'b0;
            r_locked   <= 1'b0;
            r_owner    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_valid) r_cap_lock <= w_grant_port ? lock1 : lock0;
            if (w_lock_release) r_locked <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_locked <= r_cap_lock;
            r_owner  <= r_gnt;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = lock0 ^ lock1;
    assign w_owner_port  = 1'b0;
    assign w_owner_req   = 1'b0;
    assign w_lock_active = 1'b0;
`endif

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_port  = 1'b0;
        if (w_lock_active) begin
            w_grant_valid = w_owner_req;
            w_grant_port  = w_owner_port;
        end else if (req0 && req1) begin
            w_grant_valid = 1'b1;
            w_grant_port  = ~r_last_grant;
        end else if (req0 || req1) begin
            w_grant_valid = 1'b1;
            w_grant_port  = req1;
        end
    end

    assign w_sel_rw    = w_grant_port ? rw1 : rw0;
    assign w_sel_addr  = w_grant_port ? addr1 : addr0;
    assign w_sel_wdata = w_grant_port ? wdata1 : wdata0;

    // mem_rw/mem_addr/mem_wdata double as the captured request, so later requester changes cannot leak in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= 3'd0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            mem_en       <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt        <= w_grant_port;
                        r_last_grant <= w_grant_port;
                        mem_en       <= 1'b1;
                        mem_rw       <= w_sel_rw;
                        mem_addr     <= w_sel_addr & ADDR_MASK;
                        mem_wdata    <= w_sel_wdata;
                        busy         <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_en <= 1'b0;
                    if (mem_rw) begin
                        ack0    <= ~r_gnt;
                        ack1    <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_wait_cnt <= LAT_LOAD;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 3'd1) begin
                        if (r_gnt) rdata1 <= mem_rdata;
                        else       rdata0 <= mem_rdata;
                        ack0    <= ~r_gnt;
                        ack1    <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// Lock expectations follow MEM_ARB_LOCK_EN when the bench is built with that macro.
module tb_mem_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, rw0, rw1, lock0, lock1, ack0, ack1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic          mem_en, mem_rw, busy;

    logic [1:0]    d_req, d_rw, d_lock;
    logic [AW-1:0] d_addr [2];
    logic [DW-1:0] d_wdata [2];

    assign req0   = d_req[0];
    assign req1   = d_req[1];
    assign rw0    = d_rw[0];
    assign rw1    = d_rw[1];
    assign lock0  = d_lock[0];
    assign lock1  = d_lock[1];
    assign addr0  = d_addr[0];
    assign addr1  = d_addr[1];
    assign wdata0 = d_wdata[0];
    assign wdata1 = d_wdata[1];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: one outstanding transaction described by its issue and ack cycles
    logic          m_last;
    logic          m_locked;
    int            m_owner;
    int            m_idle_at;
    logic          t_valid;
    int            t_port;
    logic          t_rw;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    int            t_issue, t_ack;
    logic          m_mem_rw;
    logic [AW-1:0] m_mem_addr;
    logic [DW-1:0] m_mem_wdata;
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] mdl_mem [16];

    logic [DW-1:0] ram [16];
    int            rd_due;
    logic [DW-1:0] rd_data;

    txn_t          q0[$], q1[$];
    logic [1:0]    granted;
    int            load_pct, gap_pct, b2b_pct, scr_pct, lock_pct;
    logic          rst_arm, rst_fired;
    int            rst_hold;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.rw    = 1'($urandom_range(0, 1));
        t.addr  = $urandom();
        t.wdata = $urandom();
        t.lock  = ($urandom_range(0, 99) < lock_pct);
        return t;
    endfunction

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_txn(input int p, input txn_t t);
        if (p == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    task automatic present(input int p);
        txn_t t;
        if (p == 0) t = q0[0];
        else        t = q1[0];
        d_req[p]   = 1'b1;
        d_rw[p]    = t.rw;
        d_addr[p]  = t.addr;
        d_wdata[p] = t.wdata;
        d_lock[p]  = t.lock;
    endtask

    task automatic model_reset();
        t_valid     = 1'b0;
        m_last      = 1'b1;
        m_locked    = 1'b0;
        m_owner     = 0;
        m_idle_at   = 32'h3fff_ffff;
        m_mem_rw    = 1'b0;
        m_mem_addr  = '0;
        m_mem_wdata = '0;
        m_rdata[0]  = '0;
        m_rdata[1]  = '0;
        granted     = 2'b00;
    endtask

    task automatic step();
        int         w;
        logic [1:0] r;
        @(negedge clk);
        if (t_valid && cyc == t_issue) begin
            m_mem_rw    = t_rw;
            m_mem_addr  = t_addr;
            m_mem_wdata = t_wdata;
        end
        if (t_valid && cyc == t_ack && !t_rw) m_rdata[t_port] = t_rdata;
        check_eq("ack0", ack0, t_valid && cyc == t_ack && t_port == 0);
        check_eq("ack1", ack1, t_valid && cyc == t_ack && t_port == 1);
        check_eq("mem_en", mem_en, t_valid && cyc == t_issue);
        check_eq("busy", busy, t_valid && cyc >= t_issue && cyc <= t_ack);
        check_eq("mem_rw", mem_rw, m_mem_rw);
        check_eq("mem_addr", mem_addr, m_mem_addr);
        check_eq("mem_wdata", mem_wdata, m_mem_wdata);
        check_eq("rdata0", rdata0, m_rdata[0]);
        check_eq("rdata1", rdata1, m_rdata[1]);

        if (mem_en === 1'b1) begin
            if (mem_rw) ram[mem_addr[5:2]] = mem_wdata;
            else begin
                rd_due  = cyc + RD_LAT;
                rd_data = ram[mem_addr[5:2]];
            end
        end
        mem_rdata = (cyc == rd_due) ? rd_data : DW'($urandom());

        if (rst_arm && t_valid && !t_rw && cyc == t_issue + 2) begin
            reset_n = 1'b0;
            #1;
            check_eq("rst_ack0", ack0, 0);
            check_eq("rst_ack1", ack1, 0);
            check_eq("rst_rdata0", rdata0, 0);
            check_eq("rst_rdata1", rdata1, 0);
            check_eq("rst_mem_en", mem_en, 0);
            check_eq("rst_mem_rw", mem_rw, 0);
            check_eq("rst_mem_addr", mem_addr, 0);
            check_eq("rst_mem_wdata", mem_wdata, 0);
            check_eq("rst_busy", busy, 0);
            rst_arm   = 1'b0;
            rst_fired = 1'b1;
            rst_hold  = 3;
            model_reset();
            q0.delete();
            q1.delete();
            d_req = 2'b00;
        end else if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) begin
                reset_n   = 1'b1;
                m_idle_at = cyc;
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (load_pct > 0 && qsize(p) < 3 && $urandom_range(0, 99) < load_pct) push_txn(p, rand_txn());
            if (d_req[p] && ((p == 0) ? ack0 : ack1) === 1'b1) begin
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                d_req[p]   = 1'b0;
                granted[p] = 1'b0;
                if (qsize(p) > 0 && $urandom_range(0, 99) < b2b_pct) present(p);
            end else if (!d_req[p] && reset_n && qsize(p) > 0 && $urandom_range(0, 99) >= gap_pct) begin
                present(p);
            end else if (d_req[p] && granted[p] && $urandom_range(0, 99) < scr_pct) begin
                d_rw[p]    = ~d_rw[p];
                d_addr[p]  = $urandom();
                d_wdata[p] = $urandom();
                d_lock[p]  = ~d_lock[p];
            end else if (!d_req[p] && $urandom_range(0, 99) < 20) begin
                d_lock[p] = ($urandom_range(0, 99) < lock_pct);
            end
        end

        if (reset_n && cyc >= m_idle_at) begin
            r = d_req;
            w = -1;
`ifdef MEM_ARB_LOCK_EN
            if (m_locked && !d_req[m_owner] && !d_lock[m_owner]) m_locked = 1'b0;
            if (m_locked) r[1 - m_owner] = 1'b0;
`endif
            if (r == 2'b11)  w = m_last ? 0 : 1;
            else if (r[0])   w = 0;
            else if (r[1])   w = 1;
            if (w >= 0) begin
                t_valid   = 1'b1;
                t_port    = w;
                t_rw      = d_rw[w];
                t_addr    = d_addr[w] & 32'hFFFF_FFFC;
                t_wdata   = d_wdata[w];
                t_issue   = cyc + 1;
                t_ack     = cyc + 2 + (t_rw ? 0 : RD_LAT);
                m_idle_at = t_ack + 1;
                m_last    = (w == 1);
                if (t_rw) mdl_mem[t_addr[5:2]] = t_wdata;
                else      t_rdata = mdl_mem[t_addr[5:2]];
                m_locked  = d_lock[w];
                m_owner   = w;
                granted[w] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic set_knobs(input int ld, input int gp, input int bb, input int sc, input int lk);
        load_pct = ld;
        gap_pct  = gp;
        b2b_pct  = bb;
        scr_pct  = sc;
        lock_pct = lk;
    endtask

    initial begin
        txn_t t;
        int   guard;
        d_req      = 2'b00;
        d_rw       = 2'b00;
        d_lock     = 2'b00;
        d_addr[0]  = '0;
        d_addr[1]  = '0;
        d_wdata[0] = '0;
        d_wdata[1] = '0;
        mem_rdata  = '0;
        reset_n    = 1'b0;
        rd_due     = -1;
        rd_data    = '0;
        rst_arm    = 1'b0;
        rst_fired  = 1'b0;
        rst_hold   = 0;
        set_knobs(0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 16; i++) begin
            ram[i]     = $urandom();
            mdl_mem[i] = ram[i];
        end
        ram[0]     = 32'h1234_5678;
        mdl_mem[0] = 32'h1234_5678;

        repeat (3) step();
        reset_n   = 1'b1;
        m_idle_at = cyc;

        // single write with unaligned address and single read, raised together from reset
        push_txn(0, '{1'b1, 32'h0000_0107, 32'hDEAD_BEEF, 1'b0});
        push_txn(1, '{1'b0, 32'h0000_0040, 32'h0, 1'b0});
        repeat (20) step();

        // port 0 two writes (lock then unlock) while port 1 waits
        push_txn(0, '{1'b1, 32'h0000_0208, $urandom(), 1'b1});
        push_txn(0, '{1'b1, 32'h0000_020C, $urandom(), 1'b0});
        push_txn(1, '{1'b1, 32'h0000_0310, $urandom(), 1'b0});
        set_knobs(0, 0, 100, 0, 0);
        repeat (25) step();

        // contention: four back-to-back transactions per port
        for (int i = 0; i < 4; i++) begin
            push_txn(0, rand_txn());
            push_txn(1, rand_txn());
        end
        repeat (70) step();

        // random traffic including post-grant changes to the request inputs
        set_knobs(30, 40, 50, 30, 30);
        repeat (2500) step();

        set_knobs(0, 0, 50, 0, 0);
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0 || d_req != 2'b00 || cyc <= m_idle_at) && guard < 400) begin
            step();
            guard++;
        end
        check_eq("drain_timeout", guard < 400, 1);

        // reset during a read's WAIT, then a normal read
        t = '{1'b0, 32'h0000_0044, 32'h0, 1'b0};
        push_txn(0, t);
        rst_arm = 1'b1;
        repeat (40) step();
        check_eq("reset_fired", rst_fired, 1);
        push_txn(0, '{1'b0, 32'h0000_0048, 32'h0, 1'b0});
        repeat (20) step();
        check_eq("post_reset_read_done", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single memory port (address / data_out / data_rw / data_in) between two requesters: port 0 = CPU control core, port 1 = DMA / debug loader.
- Each requester gets a req/ack handshake. The arbiter sequences one memory transaction at a time with a fixed read latency.
- Arbitration is round-robin. The arbiter sits between the core/DMA and the RAM model or block RAM.

Parameters:
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..7

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request; held high and stable until the matching ack
- rw0 / rw1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  byte address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  keep ownership after this transaction (see Optional Feature)
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data; valid with ack, held until that port's next read ack
- mem_en  out  1  one-cycle transaction strobe
- mem_rw  out  1  1 = write
- mem_addr  out  AW  address with bits [1:0] forced to 0
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data from memory
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - State goes to IDLE; the in-flight transaction is dropped with no ack.
  - All outputs reset to 0: ack*, rdata*, mem_*, busy.
  - last_grant resets to 1, so port 0 wins the first tie.
- State machine: IDLE -> ISSUE -> (WAIT if read) -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Sample req0 and req1.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant: capture rw/addr/wdata/lock of the granted port into internal registers, set gnt and last_grant, go to ISSUE.
- ISSUE:
  - mem_en = 1 for exactly one cycle, with mem_rw/mem_addr/mem_wdata from the captured registers.
  - Write: go to DONE.
  - Read: load wait counter = RD_LAT, go to WAIT.
- WAIT:
  - mem_en = 0. The counter decrements each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into rdata[gnt] and go to DONE.
  - WAIT lasts exactly RD_LAT cycles.
- DONE: ack[gnt] = 1 for one cycle, then go to IDLE.
- Requester rule: drop req on the edge where ack is sampled high. Req still high in the following IDLE is a new request.
- Latency: request sampled at edge T.
  - mem_en is high in cycle T+1.
  - Write ack is in cycle T+2.
  - Read ack is in cycle T+2+RD_LAT.
- Throughput: one transaction per 3 cycles (write) or 3+RD_LAT cycles (read).
- The captured request is immune to requester changes after the grant.
- mem_addr[1:0] = 0 always (word-aligned bus).
- Outside ISSUE: mem_en = 0; mem_rw/mem_addr/mem_wdata hold their last values.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - If the captured lock = 1, the arbiter enters a locked condition owned by gnt.
  - While locked, IDLE grants only the owner; the other port's req is ignored (it starves).
  - Lock is released when either (a) the owner completes a transaction captured with lock = 0, or (b) in IDLE the owner has req = 0 and lock = 0.
  - Reset clears the lock.
  - Typical use: CPU interrupt entry pushes two words back-to-back.
- Undefined: lock0/lock1 are ignored (unconnected internally) and every transaction is arbitrated independently.

Test Plan:
1. Reset:
   - Stimulus: reset_n low mid-read (state WAIT, RD_LAT = 3).
   - Response: all outputs 0 immediately; no ack after release; the next req0 read completes normally.
2. Single write:
   - Stimulus: req0 = 1, rw0 = 1, addr0 = 0x00000107, wdata0 = 0xDEADBEEF.
   - Response: mem_en at T+1 with mem_addr = 0x00000104; ack0 at T+2.
3. Single read, RD_LAT = 2:
   - Stimulus: req1 read, addr1 = 0x40, memory returns 0x12345678 two cycles after mem_en.
   - Response: ack1 at T+4 with rdata1 = 0x12345678; rdata1 holds after ack.
4. Contention:
   - Stimulus: req0 and req1 both held high for 4 transactions each, asserted from reset.
   - Response: grant order 0,1,0,1,...; no two acks in the same cycle; busy low for exactly one IDLE cycle between transactions.
5. Lock (MEM_ARB_LOCK_EN):
   - Stimulus: port 0 issues 2 writes with lock0 = 1 then lock0 = 0 while req1 stays high.
   - Response: both port 0 writes complete before port 1 is granted.
   - Without the macro: the same stimulus gives order 0,1,0.
6. Hold-stable:
   - Stimulus: change addr0 from 0x10 to 0x20 in the ISSUE cycle.
   - Response: mem_addr = 0x10.
